pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

- Hazard and stall controller for the 5-stage pipelined MIPS core.
- Generates the forwarding selects, and the stall/flush controls that drive the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Its FlushE output feeds the ID/EX register's CLR_sync.
- Adds a sequenced data-memory wait handshake with a timeout fault state, plus a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum consecutive wait cycles tolerated in MEM_WAIT before faulting.
- CNT_W, 16: stall-counter width.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- RsD, RtD  in  5  source registers in Decode.
- RsE, RtE  in  5  source registers in Execute.
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1  write-enable per stage.
- MemtoRegE, MemtoRegM  in  1  load in stage.
- BranchD  in  1  branch instruction in Decode.
- PCSrcD  in  1  branch taken (resolved in Decode).
- JumpD  in  1  jump in Decode.
- MemReqM  in  1  Memory stage issues a data-memory access (load, store, push or pop).
- MemReadyM  in  1  data memory completes the access this cycle.
- ClrCount  in  1  synchronous clear of StallCount.
- ForwardAE, ForwardBE  out  2  ALU operand select:
  - 00 = register file
  - 01 = WB result
  - 10 = MEM ALU result
- ForwardAD, ForwardBD  out  1  forward MEM ALU result to the branch comparator.
- StallF, StallD  out  1  hold the PC and the IF/ID register.
- StallE, StallM  out  1  hold the ID/EX and EX/MEM registers.
- FlushD  out  1  clear IF/ID.
- FlushE  out  1  clear ID/EX (drives its CLR_sync).
- FlushW  out  1  clear MEM/WB, inserting a writeback bubble.
- MemTimeout  out  1  sticky fault flag.
- StallCount  out  CNT_W  count of cycles with StallF=1.

## Operation
Forwarding (combinational):
- ForwardAE = 10 if RegWriteM and WriteRegM!=0 and WriteRegM==RsE.
- Otherwise ForwardAE = 01 if RegWriteW and WriteRegW!=0 and WriteRegW==RsE.
- Otherwise ForwardAE = 00. ForwardBE is the same using RtE. The MEM stage has priority over WB.
- ForwardAD = RegWriteM and WriteRegM!=0 and WriteRegM==RsD. ForwardBD is the same using RtD.

Hazard terms (combinational):
- lwstall = MemtoRegE and WriteRegE!=0 and (WriteRegE==RsD or WriteRegE==RtD).
- brstall = BranchD and either:
  - RegWriteE and WriteRegE!=0 and WriteRegE matches RsD or RtD, or
  - MemtoRegM and WriteRegM!=0 and WriteRegM matches RsD or RtD.
- memstall:
  - in IDLE: MemReqM and not MemReadyM;
  - in MEM_WAIT: not MemReadyM;
  - in FAULT: always 1.

Outputs:
- StallF = StallD = lwstall or brstall or memstall.
- StallE = StallM = memstall.
- FlushE = (lwstall or brstall) and not memstall. During a memory stall, EX is held, never cleared.
- FlushD = (PCSrcD or JumpD) and not StallD.
- FlushW = memstall, so a held MEM instruction is not written back twice.

Wait-state FSM (states IDLE, MEM_WAIT, FAULT; wait counter of width clog2(MEM_TIMEOUT+1)):
- IDLE:
  - MemReqM and not MemReadyM: go to MEM_WAIT, wait counter = 1.
  - Otherwise stay in IDLE.
- MEM_WAIT:
  - MemReadyM: go to IDLE, wait counter = 0. The stall drops in that same cycle.
  - Else, wait counter == MEM_TIMEOUT: go to FAULT and set MemTimeout.
  - Else: increment the wait counter.
- FAULT: terminal until reset. All stalls held, MemTimeout=1.

StallCount:
- Increments each cycle StallF=1.
- Saturates at all-ones.
- ClrCount wins over increment; the counter reads 0 on the next cycle.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the current state, with zero-cycle latency.
- The registered elements are the FSM state, the wait counter, MemTimeout and StallCount.
- While reset is asserted:
  - state = IDLE, wait counter = 0, MemTimeout = 0, StallCount = 0.
  - All stall and flush outputs are forced to 0 and all forward selects to 00.
- Reset mid-wait or in FAULT returns to IDLE immediately (asynchronous).
- A memory access with MemReadyM=1 in the same cycle as MemReqM causes no stall.
- A memory wait of N cycles yields exactly N stall cycles.
- Simultaneous lwstall and memstall:
  - The memory stall dominates: FlushE=0 and StallE=1.
  - The load-use bubble is inserted on the first cycle after memstall deasserts.
- FlushD is suppressed whenever StallD=1. The branch re-resolves after the stall.

## Structure
- Package hazard_pkg holds:
  - the state enum (IDLE, MEM_WAIT, FAULT);
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the default MEM_TIMEOUT.
- Sub-module forward_unit is purely combinational and computes ForwardAE/BE/AD/BD. The top level holds the hazard terms, the FSM and the counters.

## Test plan
- Forwarding priority: RsE=5, WriteRegM=5, WriteRegW=5, both RegWrite=1 -> ForwardAE=10. Repeat with WriteRegM=0 and RegWriteM=1 -> ForwardAE=01.
- Load-use: MemtoRegE=1, WriteRegE=8, RtD=8 -> StallF=StallD=FlushE=1 for exactly one cycle, StallE=0, StallCount increments by 1.
- Memory wait: MemReqM=1, MemReadyM low for 3 cycles then high -> StallF/D/E/M=FlushW=1 for exactly 3 cycles, FlushE=0, state returns to IDLE.
- Timeout: MEM_TIMEOUT=4, MemReadyM held low -> MemTimeout rises after 4 MEM_WAIT cycles, stalls stay high. Asserting reset mid-FAULT clears everything.
- Branch: PCSrcD=1 with no hazard -> FlushD=1. With brstall (RegWriteE=1, WriteRegE=RsD=3) -> FlushD=0 and FlushE=1.
- Counter saturation: CNT_W=4, stall for 20 cycles -> StallCount=15. ClrCount=1 -> StallCount reads 0 on the next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forwarding selects for the ALU and the Decode branch comparator.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs_d,
  input  logic [4:0] i_rt_d,
  input  logic [4:0] i_rs_e,
  input  logic [4:0] i_rt_e,
  input  logic [4:0] i_write_reg_m,
  input  logic [4:0] i_write_reg_w,
  input  logic       i_reg_write_m,
  input  logic       i_reg_write_w,
  output logic [1:0] o_forward_ae,
  output logic [1:0] o_forward_be,
  output logic       o_forward_ad,
  output logic       o_forward_bd
);

  logic w_m_live;
  logic w_w_live;

  // Register 0 is hard-wired, so a write to it never produces a forwardable value.
  assign w_m_live = i_reg_write_m && (i_write_reg_m != 5'd0);
  assign w_w_live = i_reg_write_w && (i_write_reg_w != 5'd0);

  always_comb begin
    o_forward_ae = FWD_RF;
    o_forward_be = FWD_RF;
    if (w_m_live && (i_write_reg_m == i_rs_e))      o_forward_ae = FWD_MEM;
    else if (w_w_live && (i_write_reg_w == i_rs_e)) o_forward_ae = FWD_WB;
    if (w_m_live && (i_write_reg_m == i_rt_e))      o_forward_be = FWD_MEM;
    else if (w_w_live && (i_write_reg_w == i_rt_e)) o_forward_be = FWD_WB;
  end

  assign o_forward_ad = w_m_live && (i_write_reg_m == i_rs_d);
  assign o_forward_bd = w_m_live && (i_write_reg_m == i_rt_d);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: forwarding, load-use and
// branch stalls, data-memory wait handshake with timeout fault, and a stall counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             JumpD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             ClrCount,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  hz_state_t         r_state, w_state_next;
  logic [WAIT_W-1:0] r_wait, w_wait_next;
  logic              r_timeout, w_timeout_next;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0] w_fae, w_fbe;
  logic       w_fad, w_fbd;
  logic       w_lwstall, w_brstall, w_memstall, w_stall_fd;

  forward_unit u_fwd (
    .i_rs_d        (RsD),
    .i_rt_d        (RtD),
    .i_rs_e        (RsE),
    .i_rt_e        (RtE),
    .i_write_reg_m (WriteRegM),
    .i_write_reg_w (WriteRegW),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_forward_ae  (w_fae),
    .o_forward_be  (w_fbe),
    .o_forward_ad  (w_fad),
    .o_forward_bd  (w_fbd)
  );

  assign w_lwstall = MemtoRegE && (WriteRegE != 5'd0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign w_brstall = BranchD &&
                     ((RegWriteE && (WriteRegE != 5'd0) &&
                       ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                      (MemtoRegM && (WriteRegM != 5'd0) &&
                       ((WriteRegM == RsD) || (WriteRegM == RtD))));

  always_comb begin
    w_state_next   = r_state;
    w_wait_next    = r_wait;
    w_timeout_next = r_timeout;
    w_memstall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          w_memstall   = 1'b1;
          w_state_next = MEM_WAIT;
          w_wait_next  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          w_state_next = IDLE;
          w_wait_next  = '0;
        end else begin
          w_memstall = 1'b1;
          if (r_wait == WAIT_MAX) begin
            w_state_next   = FAULT;
            w_timeout_next = 1'b1;
          end else begin
            w_wait_next = r_wait + WAIT_W'(1);
          end
        end
      end
      FAULT: begin
        w_memstall     = 1'b1;
        w_timeout_next = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_wait    <= w_wait_next;
      r_timeout <= w_timeout_next;
    end
  end

  // Reset forces every combinational control to its inactive value.
  assign w_stall_fd = !reset && (w_lwstall || w_brstall || w_memstall);
  assign StallF     = w_stall_fd;
  assign StallD     = w_stall_fd;
  assign StallE     = !reset && w_memstall;
  assign StallM     = !reset && w_memstall;
  assign FlushW     = !reset && w_memstall;
  assign FlushE     = !reset && (w_lwstall || w_brstall) && !w_memstall;
  assign FlushD     = !reset && (PCSrcD || JumpD) && !w_stall_fd;
  assign ForwardAE  = reset ? FWD_RF : w_fae;
  assign ForwardBE  = reset ? FWD_RF : w_fbe;
  assign ForwardAD  = !reset && w_fad;
  assign ForwardBD  = !reset && w_fbd;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (ClrCount) begin
      r_cnt <= '0;
    end else if (w_stall_fd && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign MemTimeout = r_timeout;
  assign StallCount = r_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: each driven cycle pushes its hand-computed response; a monitor
// pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       fad;
    logic       fbd;
    logic       sf;
    logic       sd;
    logic       se;
    logic       sm;
    logic       fd;
    logic       fe;
    logic       fw;
    logic       to;
    logic [3:0] cnt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, JumpD, MemReqM, MemReadyM, ClrCount;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW, MemTimeout;
  logic [3:0] StallCount;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad = 0;
  int    n_pushed = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .CLK(CLK), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ClrCount(ClrCount),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .StallCount(StallCount)
  );

  function automatic exp_t mk(input logic [1:0] fae, input logic [1:0] fbe,
                              input logic fad, input logic fbd,
                              input logic sfd, input logic sem,
                              input logic fd, input logic fe, input logic fw,
                              input logic to, input logic [3:0] cnt);
    exp_t e;
    e.fae = fae; e.fbe = fbe; e.fad = fad; e.fbd = fbd;
    e.sf = sfd; e.sd = sfd; e.se = sem; e.sm = sem;
    e.fd = fd; e.fe = fe; e.fw = fw; e.to = to; e.cnt = cnt;
    return e;
  endfunction

  task automatic clr_in();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; PCSrcD = 0; JumpD = 0;
    MemReqM = 0; MemReadyM = 0; ClrCount = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    clr_in();
  endtask

  task automatic expect_now(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    n_pushed++;
  endtask

  // Monitor: one comparison per pushed expectation, sampled mid-cycle.
  initial begin
    exp_t  e;
    exp_t  a;
    string t;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a.fae = ForwardAE; a.fbe = ForwardBE; a.fad = ForwardAD; a.fbd = ForwardBD;
        a.sf = StallF; a.sd = StallD; a.se = StallE; a.sm = StallM;
        a.fd = FlushD; a.fe = FlushE; a.fw = FlushW; a.to = MemTimeout;
        a.cnt = StallCount;
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got %h want %h (fae,fbe,fad,fbd,sf,sd,se,sm,fd,fe,fw,to,cnt)",
                   t, a, e);
        end else begin
          $display("ok   %s: %h", t, a);
        end
      end
    end
  end

  initial begin
    logic [3:0] cntv;
    clr_in();

    // Reset forces outputs low even with hazard-producing inputs present
    next_cycle(); reset = 1;
    RsE = 5; WriteRegM = 5; RegWriteM = 1; MemReqM = 1; MemtoRegE = 1; WriteRegE = 8; RtD = 8;
    PCSrcD = 1;
    expect_now("reset", mk(0,0,0,0, 0,0, 0,0,0, 0, 0));
    next_cycle(); reset = 0;
    expect_now("idle", mk(0,0,0,0, 0,0, 0,0,0, 0, 0));

    // Forwarding priority
    next_cycle(); RsE = 5; RtE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
    expect_now("fwd_mem_prio", mk(2'b10,2'b10,0,0, 0,0, 0,0,0, 0, 0));
    next_cycle(); RsE = 5; RtE = 5; WriteRegM = 0; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
    expect_now("fwd_r0_to_wb", mk(2'b01,2'b01,0,0, 0,0, 0,0,0, 0, 0));
    next_cycle(); RsE = 7; RtE = 5; WriteRegM = 7; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    RsD = 7; RtD = 5;
    expect_now("fwd_mixed", mk(2'b10,2'b01,1,0, 0,0, 0,0,0, 0, 0));
    next_cycle(); RsE = 7; RtE = 5; WriteRegM = 7; RegWriteM = 0; WriteRegW = 5; RegWriteW = 1;
    RsD = 7; RtD = 5;
    expect_now("fwd_m_off", mk(2'b00,2'b01,0,0, 0,0, 0,0,0, 0, 0));

    // Load-use: one cycle stall + bubble
    next_cycle(); MemtoRegE = 1; WriteRegE = 8; RtD = 8;
    expect_now("loaduse", mk(0,0,0,0, 1,0, 0,1,0, 0, 0));
    next_cycle();
    expect_now("loaduse_after", mk(0,0,0,0, 0,0, 0,0,0, 0, 1));

    // Memory wait of 3 cycles
    for (int k = 0; k < 3; k++) begin
      next_cycle(); MemReqM = 1; MemReadyM = 0;
      cntv = 4'(1 + k);
      expect_now("memwait", mk(0,0,0,0, 1,1, 0,0,1, 0, cntv));
    end
    next_cycle(); MemReqM = 1; MemReadyM = 1;
    expect_now("memwait_done", mk(0,0,0,0, 0,0, 0,0,0, 0, 4));
    next_cycle(); MemReqM = 1; MemReadyM = 1;
    expect_now("mem_ready_same", mk(0,0,0,0, 0,0, 0,0,0, 0, 4));

    // Load-use coinciding with memory stall
    next_cycle(); MemtoRegE = 1; WriteRegE = 8; RtD = 8; MemReqM = 1; MemReadyM = 0;
    expect_now("lw_and_mem", mk(0,0,0,0, 1,1, 0,0,1, 0, 4));
    next_cycle(); MemtoRegE = 1; WriteRegE = 8; RtD = 8; MemReqM = 1; MemReadyM = 1;
    expect_now("lw_after_mem", mk(0,0,0,0, 1,0, 0,1,0, 0, 5));

    // Branch / jump flush handling
    next_cycle(); BranchD = 1; PCSrcD = 1; RsD = 3; RtD = 4;
    expect_now("br_taken", mk(0,0,0,0, 0,0, 1,0,0, 0, 6));
    next_cycle(); BranchD = 1; PCSrcD = 1; RsD = 3; RtD = 4; RegWriteE = 1; WriteRegE = 3;
    expect_now("brstall_e", mk(0,0,0,0, 1,0, 0,1,0, 0, 6));
    next_cycle(); JumpD = 1;
    expect_now("jump", mk(0,0,0,0, 0,0, 1,0,0, 0, 7));
    next_cycle(); ClrCount = 1;
    expect_now("clr", mk(0,0,0,0, 0,0, 0,0,0, 0, 7));
    next_cycle(); BranchD = 1; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 4; RtD = 4;
    expect_now("brstall_m", mk(0,0,0,1, 1,0, 0,1,0, 0, 0));

    // Counter saturation over 20 stall cycles
    for (int k = 0; k < 20; k++) begin
      next_cycle(); MemtoRegE = 1; WriteRegE = 8; RtD = 8;
      cntv = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
      expect_now("sat", mk(0,0,0,0, 1,0, 0,1,0, 0, cntv));
    end
    next_cycle();
    expect_now("sat_hold", mk(0,0,0,0, 0,0, 0,0,0, 0, 15));
    next_cycle(); ClrCount = 1; MemtoRegE = 1; WriteRegE = 8; RtD = 8;
    expect_now("clr_vs_inc", mk(0,0,0,0, 1,0, 0,1,0, 0, 15));
    next_cycle();
    expect_now("clr_result", mk(0,0,0,0, 0,0, 0,0,0, 0, 0));

    // Timeout: 1 IDLE stall cycle, 4 MEM_WAIT cycles, then FAULT
    for (int k = 0; k < 5; k++) begin
      next_cycle(); MemReqM = 1; MemReadyM = 0;
      cntv = 4'(k);
      expect_now("to_wait", mk(0,0,0,0, 1,1, 0,0,1, 0, cntv));
    end
    next_cycle(); MemReqM = 1; MemReadyM = 0;
    expect_now("fault", mk(0,0,0,0, 1,1, 0,0,1, 1, 5));
    next_cycle(); MemReadyM = 1;
    expect_now("fault_sticky", mk(0,0,0,0, 1,1, 0,0,1, 1, 6));
    next_cycle(); reset = 1; MemReqM = 1;
    expect_now("fault_reset", mk(0,0,0,0, 0,0, 0,0,0, 0, 0));
    next_cycle(); reset = 0;
    expect_now("post_reset", mk(0,0,0,0, 0,0, 0,0,0, 0, 0));
    next_cycle(); MemReqM = 1; MemReadyM = 1;
    expect_now("post_reset_idle", mk(0,0,0,0, 0,0, 0,0,0, 0, 0));

    next_cycle();
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge CLK);
    end
    #1;
    total++;
    if (exp_q.size() != 0 || total - 1 != n_pushed) begin
      bad++;
      $display("FAIL drain: checked %0d pending %0d want %0d checked",
               total - 1, exp_q.size(), n_pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
